// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator-side issue controller for the ALU enable/busy
// interface. It takes one operation at a time from decode, presents it to the
// ALU with a single-cycle enable, and waits while the ALU reports busy. When
// the ALU finishes it captures the result and the branch outcome, then
// returns them on a response channel. A flush drops the response without
// abandoning a busy ALU. A watchdog turns a stuck busy into an error response.
module alu_issue_ctrl #(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 40
) (
    input  logic             I_clk,
    input  logic             I_reset,

    // request channel from decode
    input  logic             I_req_valid,
    output logic             O_req_ready,
    input  logic [4:0]       I_req_op,
    input  logic [31:0]      I_req_a,
    input  logic [31:0]      I_req_b,
    input  logic [2:0]       I_req_cmp,
    input  logic [TAG_W-1:0] I_req_tag,
    input  logic             I_flush,

    // ALU side
    output logic             O_alu_en,
    output logic [4:0]       O_alu_op,
    output logic [31:0]      O_alu_s1,
    output logic [31:0]      O_alu_s2,
    input  logic             I_alu_busy,
    input  logic [31:0]      I_alu_data,
    input  logic             I_alu_lt,
    input  logic             I_alu_ltu,
    input  logic             I_alu_eq,

    // response channel
    output logic             O_rsp_valid,
    input  logic             I_rsp_ready,
    output logic [31:0]      O_rsp_data,
    output logic             O_rsp_taken,
    output logic             O_rsp_err,
    output logic [TAG_W-1:0] O_rsp_tag,
    output logic             O_idle
);

    // One extra bit so the counter can hold TIMEOUT-1 for any TIMEOUT and
    // still have headroom to saturate instead of wrapping.
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // branch comparison encodings (funct3)
    localparam logic [2:0] CMP_BEQ  = 3'b000;
    localparam logic [2:0] CMP_BNE  = 3'b001;
    localparam logic [2:0] CMP_BLT  = 3'b100;
    localparam logic [2:0] CMP_BGE  = 3'b101;
    localparam logic [2:0] CMP_BLTU = 3'b110;
    localparam logic [2:0] CMP_BGEU = 3'b111;

    // ------------------------------------------------------------------
    // state and holding registers
    // ------------------------------------------------------------------
    state_t            state_q,     state_d;
    logic [4:0]        hold_op_q,   hold_op_d;
    logic [31:0]       hold_a_q,    hold_a_d;
    logic [31:0]       hold_b_q,    hold_b_d;
    logic [2:0]        hold_cmp_q,  hold_cmp_d;
    logic [TAG_W-1:0]  hold_tag_q,  hold_tag_d;
    logic [CNT_W-1:0]  wd_cnt_q,    wd_cnt_d;
    logic              drop_q,      drop_d;
    logic [31:0]       rsp_data_q,  rsp_data_d;
    logic              rsp_taken_q, rsp_taken_d;
    logic              rsp_err_q,   rsp_err_d;

    logic              req_fire;
    logic              rsp_fire;
    logic              drop_now;
    logic              flag_taken;

    // Branch decision from the ALU comparison flags; unused encodings are
    // never taken.
    function automatic logic branch_taken(input logic [2:0] cmp,
                                          input logic       eq,
                                          input logic       lt,
                                          input logic       ltu);
        logic t;
        case (cmp)
            CMP_BEQ:  t = eq;
            CMP_BNE:  t = !eq;
            CMP_BLT:  t = lt;
            CMP_BGE:  t = !lt;
            CMP_BLTU: t = ltu;
            CMP_BGEU: t = !ltu;
            default:  t = 1'b0;
        endcase
        return t;
    endfunction

    // handshake and flag decode helpers
    always_comb begin
        req_fire   = O_req_ready && I_req_valid;
        rsp_fire   = O_rsp_valid && I_rsp_ready;
        // a flush arriving in the capture cycle must also suppress the response
        drop_now   = drop_q || I_flush;
        flag_taken = branch_taken(hold_cmp_q, I_alu_eq, I_alu_lt, I_alu_ltu);
    end

    // next-state and next-register logic
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned; that is what keeps this block from inferring
        // latches.
        state_d     = state_q;
        hold_op_d   = hold_op_q;
        hold_a_d    = hold_a_q;
        hold_b_d    = hold_b_q;
        hold_cmp_d  = hold_cmp_q;
        hold_tag_d  = hold_tag_q;
        wd_cnt_d    = wd_cnt_q;
        drop_d      = drop_q;
        rsp_data_d  = rsp_data_q;
        rsp_taken_d = rsp_taken_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    hold_op_d  = I_req_op;
                    hold_a_d   = I_req_a;
                    hold_b_d   = I_req_b;
                    hold_cmp_d = I_req_cmp;
                    hold_tag_d = I_req_tag;
                    state_d    = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // fresh operation: watchdog restarts, and only a flush seen
                // right now can mark it for dropping
                wd_cnt_d = '0;
                drop_d   = I_flush;
                state_d  = ST_WAIT;
            end

            ST_WAIT: begin
                drop_d = drop_now;
                if (!I_alu_busy) begin
                    if (drop_now) begin
                        state_d = ST_IDLE;
                    end else begin
                        rsp_data_d  = I_alu_data;
                        rsp_taken_d = flag_taken;
                        rsp_err_d   = 1'b0;
                        state_d     = ST_RESP;
                    end
                end else if (wd_cnt_q == CNT_LAST) begin
                    // ALU never released busy; report an error instead of
                    // waiting forever
                    if (drop_now) begin
                        state_d = ST_IDLE;
                    end else begin
                        rsp_data_d  = '0;
                        rsp_taken_d = 1'b0;
                        rsp_err_d   = 1'b1;
                        state_d     = ST_RESP;
                    end
                end else if (wd_cnt_q != CNT_MAX) begin
                    wd_cnt_d = wd_cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                // a handshake in the same cycle as a flush still delivers;
                // either way the response is finished
                if (rsp_fire || I_flush) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // register update with synchronous reset
    always_ff @(posedge I_clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples its next value from the same clock edge.
        if (I_reset) begin
            state_q     <= ST_IDLE;
            hold_op_q   <= '0;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            hold_cmp_q  <= '0;
            hold_tag_q  <= '0;
            wd_cnt_q    <= '0;
            drop_q      <= 1'b0;
            rsp_data_q  <= '0;
            rsp_taken_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_op_q   <= hold_op_d;
            hold_a_q    <= hold_a_d;
            hold_b_q    <= hold_b_d;
            hold_cmp_q  <= hold_cmp_d;
            hold_tag_q  <= hold_tag_d;
            wd_cnt_q    <= wd_cnt_d;
            drop_q      <= drop_d;
            rsp_data_q  <= rsp_data_d;
            rsp_taken_q <= rsp_taken_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // output drive: ALU operands come straight from the holding registers so
    // they stay stable while a multi-cycle shift reads them
    always_comb begin
        O_req_ready = (state_q == ST_IDLE) && !I_flush;
        O_idle      = (state_q == ST_IDLE);
        O_alu_en    = (state_q == ST_ISSUE);
        O_alu_op    = hold_op_q;
        O_alu_s1    = hold_a_q;
        O_alu_s2    = hold_b_q;
        O_rsp_valid = (state_q == ST_RESP);
        O_rsp_data  = rsp_data_q;
        O_rsp_taken = rsp_taken_q;
        O_rsp_err   = rsp_err_q;
        O_rsp_tag   = hold_tag_q;
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU stub.
module tb_alu_issue_ctrl;

    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 40;

    // opcode values understood by the ALU stub
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_SLL = 5'd2;
    localparam logic [4:0] OP_SRA = 5'd3;

    logic             I_clk;
    logic             I_reset;
    logic             I_req_valid;
    logic             O_req_ready;
    logic [4:0]       I_req_op;
    logic [31:0]      I_req_a;
    logic [31:0]      I_req_b;
    logic [2:0]       I_req_cmp;
    logic [TAG_W-1:0] I_req_tag;
    logic             I_flush;
    logic             O_alu_en;
    logic [4:0]       O_alu_op;
    logic [31:0]      O_alu_s1;
    logic [31:0]      O_alu_s2;
    logic             I_alu_busy;
    logic [31:0]      I_alu_data;
    logic             I_alu_lt;
    logic             I_alu_ltu;
    logic             I_alu_eq;
    logic             O_rsp_valid;
    logic             I_rsp_ready;
    logic [31:0]      O_rsp_data;
    logic             O_rsp_taken;
    logic             O_rsp_err;
    logic [TAG_W-1:0] O_rsp_tag;
    logic             O_idle;

    alu_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .I_clk       (I_clk),
        .I_reset     (I_reset),
        .I_req_valid (I_req_valid),
        .O_req_ready (O_req_ready),
        .I_req_op    (I_req_op),
        .I_req_a     (I_req_a),
        .I_req_b     (I_req_b),
        .I_req_cmp   (I_req_cmp),
        .I_req_tag   (I_req_tag),
        .I_flush     (I_flush),
        .O_alu_en    (O_alu_en),
        .O_alu_op    (O_alu_op),
        .O_alu_s1    (O_alu_s1),
        .O_alu_s2    (O_alu_s2),
        .I_alu_busy  (I_alu_busy),
        .I_alu_data  (I_alu_data),
        .I_alu_lt    (I_alu_lt),
        .I_alu_ltu   (I_alu_ltu),
        .I_alu_eq    (I_alu_eq),
        .O_rsp_valid (O_rsp_valid),
        .I_rsp_ready (I_rsp_ready),
        .O_rsp_data  (O_rsp_data),
        .O_rsp_taken (O_rsp_taken),
        .O_rsp_err   (O_rsp_err),
        .O_rsp_tag   (O_rsp_tag),
        .O_idle      (O_idle)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    // ALU stub: single-cycle add/sub; shifts stay busy for shamt+1 cycles
    // and compute from the live operands when busy falls. alu_stuck forces
    // busy high to exercise the watchdog.
    logic        alu_busy_r;
    logic [4:0]  alu_cnt;
    logic        alu_stuck;

    assign I_alu_busy = alu_busy_r | alu_stuck;
    assign I_alu_eq   = (O_alu_s1 == O_alu_s2);
    assign I_alu_lt   = ($signed(O_alu_s1) < $signed(O_alu_s2));
    assign I_alu_ltu  = (O_alu_s1 < O_alu_s2);

    always @(posedge I_clk) begin
        if (I_reset) begin
            alu_busy_r <= 1'b0;
            alu_cnt    <= '0;
            I_alu_data <= '0;
        end else if (O_alu_en) begin
            case (O_alu_op)
                OP_ADD:  begin I_alu_data <= O_alu_s1 + O_alu_s2; alu_busy_r <= 1'b0; end
                OP_SUB:  begin I_alu_data <= O_alu_s1 - O_alu_s2; alu_busy_r <= 1'b0; end
                default: begin alu_busy_r <= 1'b1; alu_cnt <= O_alu_s2[4:0]; end
            endcase
        end else if (alu_busy_r) begin
            if (alu_cnt == 5'd0) begin
                alu_busy_r <= 1'b0;
                if (O_alu_op == OP_SLL) I_alu_data <= O_alu_s1 << O_alu_s2[4:0];
                else                    I_alu_data <= $unsigned($signed(O_alu_s1) >>> O_alu_s2[4:0]);
            end else begin
                alu_cnt <= alu_cnt - 5'd1;
            end
        end
    end

    // count delivered responses
    int rsp_count = 0;
    always @(posedge I_clk) if (O_rsp_valid && I_rsp_ready) rsp_count <= rsp_count + 1;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge I_clk);
        #1;
    endtask

    // Present a request until accepted; returns in the ISSUE cycle (N+1).
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] cmp, input logic [TAG_W-1:0] tag, output int waits);
        I_req_valid = 1'b1;
        I_req_op    = op;
        I_req_a     = a;
        I_req_b     = b;
        I_req_cmp   = cmp;
        I_req_tag   = tag;
        #1;
        waits = 0;
        while (!O_req_ready && waits < 100) begin
            step();
            waits++;
        end
        if (!O_req_ready) check("req_ready_timeout", 32'd0, 32'd1);
        step();
        I_req_valid = 1'b0;
    endtask

    // Step until O_rsp_valid; lat counts cycles after the accept cycle.
    task automatic wait_rsp(input int start, input int budget, output int lat);
        lat = start;
        while (!O_rsp_valid && lat < budget) begin
            step();
            lat++;
        end
        if (!O_rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int w;
        int lat;
        int c;
        int rc0;
        logic stable;

        I_reset     = 1'b1;
        I_req_valid = 1'b0;
        I_req_op    = '0;
        I_req_a     = '0;
        I_req_b     = '0;
        I_req_cmp   = '0;
        I_req_tag   = '0;
        I_flush     = 1'b0;
        I_rsp_ready = 1'b0;
        alu_stuck   = 1'b0;
        step(); step(); step();
        I_reset = 1'b0;
        #1;

        // reset state
        check("rst_idle",      O_idle,      1);
        check("rst_req_ready", O_req_ready, 1);
        check("rst_alu_en",    O_alu_en,    0);
        check("rst_alu_op",    O_alu_op,    0);
        check("rst_alu_s1",    O_alu_s1,    0);
        check("rst_alu_s2",    O_alu_s2,    0);
        check("rst_rsp_valid", O_rsp_valid, 0);
        check("rst_rsp_data",  O_rsp_data,  0);
        check("rst_rsp_taken", O_rsp_taken, 0);
        check("rst_rsp_err",   O_rsp_err,   0);
        check("rst_rsp_tag",   O_rsp_tag,   0);

        // ADD 5+7, BEQ not taken, latency 3
        I_rsp_ready = 1'b1;
        send(OP_ADD, 32'd5, 32'd7, 3'b000, 4'd3, w);
        check("add_alu_en", O_alu_en, 1);
        check("add_alu_s1", O_alu_s1, 5);
        check("add_alu_s2", O_alu_s2, 7);
        wait_rsp(1, 100, lat);
        check("add_lat",   lat,         3);
        check("add_data",  O_rsp_data,  12);
        check("add_taken", O_rsp_taken, 0);
        check("add_err",   O_rsp_err,   0);
        check("add_tag",   O_rsp_tag,   3);
        step();
        check("add_idle_after", O_idle, 1);

        // SUB signed/unsigned compare
        send(OP_SUB, 32'h8000_0000, 32'd1, 3'b100, 4'd5, w);
        wait_rsp(1, 100, lat);
        check("sub_lat",       lat,         3);
        check("sub_data",      O_rsp_data,  32'h7FFF_FFFF);
        check("sub_blt_taken", O_rsp_taken, 1);
        step();
        send(OP_SUB, 32'h8000_0000, 32'd1, 3'b110, 4'd6, w);
        wait_rsp(1, 100, lat);
        check("sub_bltu_taken", O_rsp_taken, 0);
        check("sub_bltu_tag",   O_rsp_tag,   6);
        step();
        send(OP_ADD, 32'd9, 32'd9, 3'b101, 4'd2, w);
        wait_rsp(1, 100, lat);
        check("bge_data",  O_rsp_data,  18);
        check("bge_taken", O_rsp_taken, 1);
        step();

        // SLL 1<<31: busy 32 cycles, response at N+35; live request bus ignored
        send(OP_SLL, 32'd1, 32'd31, 3'b000, 4'd7, w);
        check("sll_alu_en", O_alu_en, 1);
        step();
        check("sll_alu_en_once", O_alu_en, 0);
        I_req_a = 32'hFFFF_FFFF;
        #1;
        check("sll_s1_held",   O_alu_s1,    1);
        check("sll_req_ready", O_req_ready, 0);
        wait_rsp(2, 100, lat);
        check("sll_lat",  lat,        35);
        check("sll_data", O_rsp_data, 32'h8000_0000);
        check("sll_tag",  O_rsp_tag,  7);
        step();

        // backpressure for 5 cycles, then back-to-back accept
        I_rsp_ready = 1'b0;
        send(OP_ADD, 32'd100, 32'd23, 3'b000, 4'd9, w);
        wait_rsp(1, 100, lat);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (O_rsp_data !== 32'd123 || O_rsp_tag !== 4'd9 || O_rsp_valid !== 1'b1 ||
                O_req_ready !== 1'b0) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        I_rsp_ready = 1'b1;
        step();
        check("bp_idle",      O_idle,      1);
        check("bp_req_ready", O_req_ready, 1);
        send(OP_ADD, 32'd1, 32'd1, 3'b000, 4'd10, w);
        check("bp_next_waits", w, 0);
        wait_rsp(1, 100, lat);
        check("bp_next_data", O_rsp_data, 2);
        step();

        // flush during SRA by 10 at N+4: idle at N+14, no response
        rc0 = rsp_count;
        send(OP_SRA, 32'h8000_0000, 32'd10, 3'b000, 4'd11, w);
        step(); step(); step();
        I_flush = 1'b1;
        step();
        I_flush = 1'b0;
        #1;
        c = 5;
        while (!O_idle && c < 100) begin
            step();
            c++;
        end
        check("flush_idle_cycle", c,         14);
        check("flush_no_rsp",     rsp_count, rc0);
        send(OP_ADD, 32'd2, 32'd3, 3'b000, 4'd12, w);
        wait_rsp(1, 100, lat);
        check("flush_next_lat",  lat,        3);
        check("flush_next_data", O_rsp_data, 5);
        check("flush_next_tag",  O_rsp_tag,  12);
        step();

        // flush in IDLE blocks acceptance
        I_flush     = 1'b1;
        I_req_valid = 1'b1;
        #1;
        check("flush_idle_ready", O_req_ready, 0);
        step();
        I_flush     = 1'b0;
        I_req_valid = 1'b0;
        #1;
        check("flush_idle_not_acc", O_idle, 1);

        // flush in RESP drops valid next cycle
        I_rsp_ready = 1'b0;
        send(OP_ADD, 32'd4, 32'd4, 3'b000, 4'd13, w);
        wait_rsp(1, 100, lat);
        I_flush = 1'b1;
        step();
        I_flush = 1'b0;
        #1;
        check("flush_resp_valid", O_rsp_valid, 0);
        check("flush_resp_idle",  O_idle,      1);

        // stuck busy: error response after TIMEOUT busy cycles
        I_rsp_ready = 1'b1;
        alu_stuck   = 1'b1;
        send(OP_ADD, 32'd4, 32'd4, 3'b000, 4'd14, w);
        wait_rsp(1, 100, lat);
        check("wd_lat",   lat,         TIMEOUT + 2);
        check("wd_err",   O_rsp_err,   1);
        check("wd_data",  O_rsp_data,  0);
        check("wd_taken", O_rsp_taken, 0);
        check("wd_tag",   O_rsp_tag,   14);
        step();

        // reset in the middle of WAIT
        send(OP_SLL, 32'd1, 32'd5, 3'b000, 4'd15, w);
        step(); step();
        I_reset   = 1'b1;
        alu_stuck = 1'b0;
        step();
        check("rmw_idle",      O_idle,      1);
        check("rmw_alu_en",    O_alu_en,    0);
        check("rmw_alu_op",    O_alu_op,    0);
        check("rmw_alu_s1",    O_alu_s1,    0);
        check("rmw_alu_s2",    O_alu_s2,    0);
        check("rmw_rsp_valid", O_rsp_valid, 0);
        check("rmw_rsp_err",   O_rsp_err,   0);
        check("rmw_rsp_tag",   O_rsp_tag,   0);
        check("rmw_alu_busy",  I_alu_busy,  0);
        I_reset = 1'b0;
        rc0 = rsp_count;
        for (int i = 0; i < 10; i++) step();
        check("rmw_no_rsp", rsp_count, rc0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
